// File: rtl/instr_pkg.sv
// Shared encoding definitions for the instruction encoder and the control decoder.
package instr_pkg;

   // Descriptor kind carried on the input stream
   typedef enum logic [2:0] {
      K_RTYPE   = 3'd0,
      K_LW      = 3'd1,
      K_SW      = 3'd2,
      K_BEQ     = 3'd3,
      K_BLT     = 3'd4,
      K_ADDI    = 3'd5,
      K_J       = 3'd6,
      K_ILLEGAL = 3'd7
   } kind_e;

   // Opcode map; the control decoder consumes the same constants
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BLT   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Encoder session FSM
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } enc_state_e;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: descriptor kind + fields -> 32-bit MIPS word.
module instr_word_pack
   import instr_pkg::*;
(
   input  logic [2:0]  i_kind,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [5:0]  i_funct,
   input  logic [15:0] i_imm,
   input  logic [25:0] i_target,
   output logic [31:0] o_word,
   output logic        o_illegal
);

   kind_e w_kind;
   assign w_kind = kind_e'(i_kind);

   // Select opcode and field layout per kind; immediates are passed raw
   always_comb begin
      o_word    = 32'h0;
      o_illegal = 1'b0;
      case (w_kind)
         K_RTYPE: o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'b00000, i_funct};
         K_LW:    o_word = {OP_LW,   i_rs, i_rt, i_imm};
         K_SW:    o_word = {OP_SW,   i_rs, i_rt, i_imm};
         K_BEQ:   o_word = {OP_BEQ,  i_rs, i_rt, i_imm};
         K_BLT:   o_word = {OP_BLT,  i_rs, i_rt, i_imm};
         K_ADDI:  o_word = {OP_ADDI, i_rs, i_rt, i_imm};
         K_J:     o_word = {OP_J,    i_target};
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: descriptor stream in, sequential instruction-memory writes out.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] L_MAX  = '1;

   enc_state_e        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [ADDR_W:0]   r_count;
   logic              r_err;
   logic              r_last;

   logic [31:0]       w_word;
   logic              w_illegal;
   logic              w_hs;
   logic              w_wr_done;
   logic              w_at_max;

   instr_word_pack u_pack (
      .i_kind    (in_kind),
      .i_rs      (in_rs),
      .i_rt      (in_rt),
      .i_rd      (in_rd),
      .i_funct   (in_funct),
      .i_imm     (in_imm),
      .i_target  (in_target),
      .o_word    (w_word),
      .o_illegal (w_illegal)
   );

   assign w_hs      = (r_state == ST_LOAD) && in_valid;
   assign w_wr_done = (r_state == ST_WRITE) && mem_ready;
   assign w_at_max  = (r_addr == L_MAX);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: start only honoured when no session is active
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (w_hs) begin
               if (!w_illegal)   w_state_nxt = ST_WRITE;
               else if (in_last) w_state_nxt = ST_DONE;
            end
         end
         ST_WRITE: begin
            if (mem_ready) begin
               if (r_last || w_at_max) w_state_nxt = ST_DONE;
               else                    w_state_nxt = ST_LOAD;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: word capture, address/count advance, sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= L_BASE;
         r_wdata <= 32'h0;
         r_count <= '0;
         r_err   <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
            r_addr  <= L_BASE;
            r_count <= '0;
            r_err   <= 1'b0;
         end
         if (w_hs) begin
            if (w_illegal) begin
               r_err <= 1'b1;
            end else begin
               r_wdata <= w_word;
               r_last  <= in_last;
            end
         end
         if (w_wr_done) begin
            r_count <= r_count + (ADDR_W+1)'(1);
            // Overflow ends the session instead of wrapping the address
            if (!r_last) begin
               if (w_at_max) r_err  <= 1'b1;
               else          r_addr <= r_addr + ADDR_W'(1);
            end
         end
      end
   end

   assign in_ready  = (r_state == ST_LOAD);
   assign mem_we    = (r_state == ST_WRITE);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign busy      = (r_state == ST_LOAD) || (r_state == ST_WRITE);
   assign done      = (r_state == ST_DONE);
   assign err       = r_err;
   assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (default and 2-bit-address instances).
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, start2 = 1'b0;
   logic        in_valid = 1'b0, in_valid2 = 1'b0;
   logic [2:0]  in_kind = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
   logic [5:0]  in_funct = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;
   logic        in_last = 1'b0;
   logic        mem_ready = 1'b0;

   logic        in_ready, mem_we, busy, done, err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [8:0]  count;

   logic        in_ready2, mem_we2, busy2, done2, err2;
   logic [1:0]  mem_addr2;
   logic [31:0] mem_wdata2;
   logic [2:0]  count2;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  log_a[$];
   logic [31:0] log_d[$];
   logic [1:0]  log_a2[$];
   logic [31:0] log_d2[$];

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
      .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
      .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
      .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ready(mem_ready),
      .busy(busy2), .done(done2), .err(err2), .count(count2)
   );

   // Record every completed memory write
   always @(posedge clk) begin
      if (rst_n && mem_we && mem_ready) begin
         log_a.push_back(mem_addr);
         log_d.push_back(mem_wdata);
      end
      if (rst_n && mem_we2 && mem_ready) begin
         log_a2.push_back(mem_addr2);
         log_d2.push_back(mem_wdata2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input bit sel);
      if (sel) start2 = 1'b1; else start = 1'b1;
      tick();
      start = 1'b0;
      start2 = 1'b0;
   endtask

   // Present one descriptor and hold it until the handshake edge
   task automatic send(input bit sel, input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tg, input logic last);
      bit ok;
      in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = fn;
      in_imm = imm; in_target = tg; in_last = last;
      if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sel ? in_ready2 : in_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout got in_ready=0 exp in_ready=1 kind=%0d", k);
      end else begin
         tick();
      end
      in_valid = 1'b0;
      in_valid2 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      vectors++; if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin miscompares++;
         $display("FAIL reset_flags got=%b exp=00000", {in_ready, mem_we, busy, done, err}); end
      vectors++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0 || count !== 9'd0) begin miscompares++;
         $display("FAIL reset_regs got addr=%0h wdata=%0h count=%0d exp 0/0/0", mem_addr, mem_wdata, count); end
      vectors++; if (mem_addr2 !== 2'd2 || count2 !== 3'd0 || in_ready2 !== 1'b0) begin miscompares++;
         $display("FAIL reset_base2 got addr=%0d count=%0d exp addr=2 count=0", mem_addr2, count2); end
      rst_n = 1'b1;
      tick();
      vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++;
         $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done); end
   endtask

   task automatic test_addi_single();
      log_a.delete(); log_d.delete();
      pulse_start(0);
      vectors++; if (in_ready !== 1'b1 || busy !== 1'b1) begin miscompares++;
         $display("FAIL addi_load got in_ready=%b busy=%b exp 1 1", in_ready, busy); end
      mem_ready = 1'b1;
      send(0, 3'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1);
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h20220005) begin miscompares++;
         $display("FAIL addi_write got we=%b addr=%0h data=%h exp 1/0/20220005", mem_we, mem_addr, mem_wdata); end
      tick();
      mem_ready = 1'b0;
      vectors++; if (done !== 1'b1 || mem_we !== 1'b0 || count !== 9'd1 || busy !== 1'b0) begin miscompares++;
         $display("FAIL addi_done got done=%b we=%b count=%0d busy=%b exp 1/0/1/0", done, mem_we, count, busy); end
      vectors++; if (log_a.size() != 1 || mem_wdata !== 32'h20220005) begin miscompares++;
         $display("FAIL addi_log got writes=%0d wdata=%h exp 1 20220005", log_a.size(), mem_wdata); end
   endtask

   task automatic test_stall();
      bit bad;
      pulse_start(0);
      mem_ready = 1'b0;
      send(0, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF, 26'h3FFFFFF, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h00221820 || in_ready !== 1'b0) bad = 1'b1;
         tick();
      end
      vectors++; if (bad) begin miscompares++;
         $display("FAIL stall_rtype got we=%b addr=%0h data=%h rdy=%b exp 1/0/00221820/0", mem_we, mem_addr, mem_wdata, in_ready); end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      vectors++; if (in_ready !== 1'b1 || mem_addr !== 8'h01 || count !== 9'd1) begin miscompares++;
         $display("FAIL stall_advance got rdy=%b addr=%0h count=%0d exp 1/1/1", in_ready, mem_addr, count); end
      send(0, 3'd6, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hABCD, 26'h0000010, 1'b1);
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (mem_we !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 32'h08000010 || in_ready !== 1'b0) bad = 1'b1;
         tick();
      end
      vectors++; if (bad) begin miscompares++;
         $display("FAIL stall_j got we=%b addr=%0h data=%h rdy=%b exp 1/1/08000010/0", mem_we, mem_addr, mem_wdata, in_ready); end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      vectors++; if (done !== 1'b1 || count !== 9'd2) begin miscompares++;
         $display("FAIL stall_done got done=%b count=%0d exp 1 2", done, count); end
   endtask

   task automatic test_illegal();
      log_a.delete(); log_d.delete();
      pulse_start(0);
      mem_ready = 1'b1;
      send(0, 3'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b0);
      send(0, 3'd7, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 26'd1, 1'b0);
      vectors++; if (err !== 1'b1 || in_ready !== 1'b1 || mem_we !== 1'b0 || count !== 9'd1) begin miscompares++;
         $display("FAIL illegal_skip got err=%b rdy=%b we=%b count=%0d exp 1/1/0/1", err, in_ready, mem_we, count); end
      send(0, 3'd2, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
      tick();
      mem_ready = 1'b0;
      vectors++; if (done !== 1'b1 || err !== 1'b1 || count !== 9'd2) begin miscompares++;
         $display("FAIL illegal_done got done=%b err=%b count=%0d exp 1/1/2", done, err, count); end
      vectors++; if (log_a.size() != 2 || log_a[0] !== 8'h00 || log_d[0] !== 32'h8FA8FFFC ||
                     log_a[1] !== 8'h01 || log_d[1] !== 32'hAFA80004) begin miscompares++;
         $display("FAIL illegal_log got writes=%0d exp 2 (8FA8FFFC@0 AFA80004@1)", log_a.size()); end
   endtask

   task automatic test_branches();
      log_a.delete(); log_d.delete();
      pulse_start(0);
      vectors++; if (err !== 1'b0 || count !== 9'd0 || mem_addr !== 8'h00) begin miscompares++;
         $display("FAIL restart_clear got err=%b count=%0d addr=%0h exp 0/0/0", err, count, mem_addr); end
      mem_ready = 1'b1;
      send(0, 3'd3, 5'd3, 5'd4, 5'd31, 6'h3F, 16'h1234, 26'h3FFFFFF, 1'b0);
      send(0, 3'd4, 5'd3, 5'd4, 5'd31, 6'h3F, 16'h1234, 26'h3FFFFFF, 1'b1);
      tick();
      mem_ready = 1'b0;
      vectors++; if (log_a.size() != 2 || log_d[0] !== 32'h10641234 || log_d[1] !== 32'h14641234 ||
                     log_a[1] !== 8'h01) begin miscompares++;
         $display("FAIL branch_log got writes=%0d exp 2 (10641234@0 14641234@1)", log_a.size()); end
   endtask

   task automatic test_overflow();
      bit seen;
      log_a2.delete(); log_d2.delete();
      pulse_start(1);
      mem_ready = 1'b1;
      send(1, 3'd5, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
      send(1, 3'd5, 5'd2, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0);
      tick();
      vectors++; if (done2 !== 1'b1 || err2 !== 1'b1 || count2 !== 3'd2 || mem_addr2 !== 2'd3) begin miscompares++;
         $display("FAIL ovf_state got done=%b err=%b count=%0d addr=%0d exp 1/1/2/3", done2, err2, count2, mem_addr2); end
      vectors++; if (log_a2.size() != 2 || log_a2[0] !== 2'd2 || log_a2[1] !== 2'd3 ||
                     log_d2[0] !== 32'h20210001 || log_d2[1] !== 32'h20420002) begin miscompares++;
         $display("FAIL ovf_log got writes=%0d exp 2 (20210001@2 20420002@3)", log_a2.size()); end
      in_kind = 3'd5; in_last = 1'b0; in_valid2 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (in_ready2 !== 1'b0) seen = 1'b1;
         tick();
      end
      in_valid2 = 1'b0;
      mem_ready = 1'b0;
      vectors++; if (seen || log_a2.size() != 2) begin miscompares++;
         $display("FAIL ovf_third got accepted=%b writes=%0d exp 0 2", seen, log_a2.size()); end
   endtask

   task automatic test_async_reset();
      log_a.delete(); log_d.delete();
      pulse_start(0);
      mem_ready = 1'b0;
      send(0, 3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b0);
      send(0, 3'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      send(0, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'd0, 1'b0);
      tick();
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 8'h01 || err !== 1'b1) begin miscompares++;
         $display("FAIL rst_pre got we=%b addr=%0h err=%b exp 1/1/1", mem_we, mem_addr, err); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== 8'h00 ||
                     mem_wdata !== 32'h0 || count !== 9'd0) begin miscompares++;
         $display("FAIL rst_async got flags=%b addr=%0h wdata=%h count=%0d exp 00000/0/0/0",
                  {in_ready, mem_we, busy, done, err}, mem_addr, mem_wdata, count); end
      tick();
      rst_n = 1'b1;
      tick();
      pulse_start(0);
      vectors++; if (in_ready !== 1'b1 || mem_addr !== 8'h00 || count !== 9'd0 || log_a.size() != 1) begin miscompares++;
         $display("FAIL rst_restart got rdy=%b addr=%0h count=%0d writes=%0d exp 1/0/0/1", in_ready, mem_addr, count, log_a.size()); end
      mem_ready = 1'b1;
      send(0, 3'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0007, 26'd0, 1'b1);
      tick();
      mem_ready = 1'b0;
      vectors++; if (log_a.size() != 2 || log_a[1] !== 8'h00 || log_d[1] !== 32'h20220007 || count !== 9'd1) begin miscompares++;
         $display("FAIL rst_rewrite got writes=%0d count=%0d exp 2 writes (20220007@0) count=1", log_a.size(), count); end
   endtask

   task automatic test_start_ignored();
      pulse_start(0);
      mem_ready = 1'b1;
      send(0, 3'd5, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
      tick();
      mem_ready = 1'b0;
      pulse_start(0);
      vectors++; if (mem_addr !== 8'h01 || count !== 9'd1 || in_ready !== 1'b1) begin miscompares++;
         $display("FAIL start_in_load got addr=%0h count=%0d rdy=%b exp 1/1/1", mem_addr, count, in_ready); end
      send(0, 3'd5, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0);
      pulse_start(0);
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 8'h01 || count !== 9'd1) begin miscompares++;
         $display("FAIL start_in_write got we=%b addr=%0h count=%0d exp 1/1/1", mem_we, mem_addr, count); end
      mem_ready = 1'b1;
      tick();
      vectors++; if (mem_addr !== 8'h02 || count !== 9'd2) begin miscompares++;
         $display("FAIL start_resume got addr=%0h count=%0d exp 2/2", mem_addr, count); end
      send(0, 3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000ABC, 1'b1);
      tick();
      mem_ready = 1'b0;
      vectors++; if (done !== 1'b1 || count !== 9'd3) begin miscompares++;
         $display("FAIL start_final got done=%b count=%0d exp 1/3", done, count); end
   endtask

   initial begin
      test_reset();
      test_addi_single();
      test_stall();
      test_illegal();
      test_branches();
      test_overflow();
      test_async_reset();
      test_start_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Writer-side counterpart of the main control decoder: accepts instruction descriptions (kind plus fields) over a valid/ready stream and encodes each into a 32-bit MIPS word.
- Uses the same opcode map the decoder consumes. Writes words sequentially into instruction memory through a stall-able write port.
- Sits between the host/test loader and instruction memory; used for boot-time program load and self-test program generation.

Parameters:
- ADDR_W, 8, word-address width of instruction memory.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load session; honoured only in IDLE or DONE.
- in_valid  in  1  instruction descriptor valid.
- in_ready  out  1  encoder can accept a descriptor.
- in_kind  in  3  0=RTYPE 1=LW 2=SW 3=BEQ 4=BLT 5=ADDI 6=J 7=illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target.
- in_last  in  1  descriptor is the final one of the program.
- mem_we  out  1  write request to instruction memory.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  high in LOAD or WRITE.
- done  out  1  high in DONE.
- err  out  1  sticky error flag; cleared by start or reset.
- count  out  ADDR_W+1  number of words written this session.

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, count=0.
- Reset is asynchronous and may assert mid-operation. Any in-flight write is dropped; the next session restarts from BASE_ADDR.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE with start=1: go to LOAD; mem_addr=BASE_ADDR, count=0, err=0. start is ignored in LOAD and WRITE.
- LOAD: in_ready=1, combinational from state only. A handshake occurs on in_valid && in_ready at edge N.
  - Legal kind: register the encoded word into mem_wdata and go to WRITE. mem_we is high from cycle N+1.
  - Illegal kind (7): set err and write nothing. Go to DONE if in_last, else stay in LOAD.
- WRITE: in_ready=0. mem_we, mem_addr and mem_wdata are held stable until mem_ready=1. On that edge:
  - count increments.
  - If in_last was latched, go to DONE.
  - Else if mem_addr == 2^ADDR_W-1, set err (overflow) and go to DONE.
  - Otherwise mem_addr increments and the FSM returns to LOAD.
- mem_ready=1 in the same cycle mem_we first rises completes the write in one cycle. Peak throughput is one word per 2 cycles.
- mem_addr never wraps; overflow is terminal for the session.
- Encoding rules (opcode, then field order, MSB first):
  - RTYPE: 000000, rs, rt, rd, 00000, funct.
  - LW: 100011, rs, rt, imm.
  - SW: 101011, rs, rt, imm.
  - BEQ: 000100, rs, rt, imm.
  - BLT: 000101, rs, rt, imm.
  - ADDI: 001000, rs, rt, imm.
  - J: 000010, target.
  - Fields unused by a kind are ignored; no sign extension is applied.
- mem_wdata holds the last encoded word when mem_we=0.

Decomposition:
- Shared package instr_pkg holds:
  - kind_e enum (3-bit).
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BLT, OP_ADDI, OP_J. The decoder also uses these so the two stay aligned.
  - enc_state_e (IDLE/LOAD/WRITE/DONE).
- Sub-module instr_word_pack: purely combinational kind+fields -> 32-bit word plus illegal flag. The FSM, address counter and handshake live in instr_encoder.

Test Plan:
- Reset, then start; send ADDI rs=1 rt=2 imm=0x0005 with in_last=1, mem_ready=1 -> mem_we one cycle, mem_addr=0, mem_wdata=0x20220005, done=1, count=1.
- Send RTYPE rs=1 rt=2 rd=3 funct=0x20, then J target=0x0000010 last, with mem_ready held low 3 cycles per write -> mem_we/addr/wdata stable while stalled. Words 0x00221820@0 and 0x08000010@1; in_ready low during WRITE.
- Send LW rs=29 rt=8 imm=0xFFFC, then kind=7, then SW rs=29 rt=8 imm=4 last -> LW 0x8FA8FFFC@0 and SW 0xAFA80004@1; err=1, count=2, no write for the illegal descriptor.
- Run ADDR_W=2, BASE_ADDR=2 with 3 non-last descriptors -> writes at 2 and 3, err=1, DONE after the second write, third descriptor never accepted.
- Assert rst_n low while in WRITE with mem_ready=0 -> all outputs return to reset values immediately; start then restarts at BASE_ADDR with count=0.
- Pulse start while in LOAD -> ignored; mem_addr and count unchanged.
